nrisc_sequencer: RTL

//  Multicycle control FSM for the 8-bit nRisc core. Sequences the existing PC, instruction memory,

---
 rtl/nrisc_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/nrisc_sequencer.sv
// Multicycle control FSM for the 8-bit nRisc core: fetch/decode/execute/memory/writeback
// sequencing, data-memory handshake with timeout, and a retired-instruction counter.
module nrisc_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       inst,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src,
    output logic             alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             mem_read,
    output logic             mem_write,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [2:0] OP_JAL = 3'b000;
    localparam logic [2:0] OP_JR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_BEQ = 3'b011;
    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_LW  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_LA  = 3'b111;

    // Last wait count before the timeout fires; the MEM cycle holding this count faults.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [2:0]       op_reg;
    logic [7:0]       wait_reg, wait_next;
    logic             fault_reg, fault_set;
    logic [CNT_W-1:0] retired_reg;
    logic             retire;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            op_reg      <= 3'b000;
            wait_reg    <= 8'd0;
            fault_reg   <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (state_reg == S_DECODE)
                op_reg <= inst[7:5];
            if (fault_set)
                fault_reg <= 1'b1;
            if (retire)
                retired_reg <= retired_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_next = state_reg;
        wait_next  = 8'd0;
        fault_set  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src    = 1'b0;
        alu_op     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        halted     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start)
                    state_next = S_FETCH;
            end
            S_FETCH: begin
                ir_write   = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                state_next = (inst == 8'hFF) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (op_reg)
                    OP_JAL: begin
                        reg_write  = 1'b1;
                        pc_src     = 2'b10;
                        pc_write   = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_JR: begin
                        pc_src     = 2'b11;
                        pc_write   = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_ADD: begin
                        alu_src    = 1'b1;
                        state_next = S_WB;
                    end
                    OP_XOR: begin
                        alu_src    = 1'b1;
                        alu_op     = 1'b1;
                        state_next = S_WB;
                    end
                    OP_BEQ: begin
                        pc_write   = 1'b1;
                        pc_src     = zero ? 2'b01 : 2'b00;
                        state_next = S_FETCH;
                    end
                    default: begin
                        // sw/lw/la: register-operand add forms the memory address
                        state_next = S_MEM;
                    end
                endcase
            end
            S_MEM: begin
                mem_write = (op_reg == OP_SW);
                mem_read  = (op_reg != OP_SW);
                if (mem_ack) begin
                    if (op_reg == OP_SW) begin
                        pc_write   = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (wait_reg == WAIT_LAST) begin
                    fault_set  = 1'b1;
                    state_next = S_HALT;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_reg == OP_LW) || (op_reg == OP_LA);
                pc_write   = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Every retired instruction leaves through exactly one PC-writing state into FETCH.
    assign retire  = (state_next == S_FETCH) &&
                     ((state_reg == S_EXEC) || (state_reg == S_MEM) || (state_reg == S_WB));
    assign state   = state_reg;
    assign fault   = fault_reg;
    assign retired = retired_reg;

endmodule
